branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Resolution end of the branch-prediction interface: consumes predictions issued at fetch and queues them in order.
- Matches each prediction against the actual outcome when the branch resolves.
- Drives the update pair (branch, taken) back into the saturating-counter predictor, plus a one-cycle mispredict/flush pulse.
- Keeps saturating statistics counters for total resolved branches and mispredictions.

Parameters:
DEPTH, 4, number of in-flight predictions held; power of two, >= 2
STAT_W, 16, width of each statistics counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
pred_valid  input  1  prediction issued this cycle
pred_taken  input  1  predicted direction (predictor's prediction output)
pred_ready  output  1  queue can accept a prediction (not full)
res_valid  input  1  oldest outstanding branch resolves this cycle
res_taken  input  1  actual outcome of the resolving branch
branch  output  1  update strobe to predictor, one cycle
taken  output  1  actual outcome accompanying branch
mispredict  output  1  one-cycle pulse: resolved outcome differed from queued prediction
empty  output  1  no predictions outstanding
res_error  output  1  sticky: resolution arrived with empty queue
count_branches  output  STAT_W  resolved branches, saturating
count_mispred  output  STAT_W  mispredictions, saturating

Behaviour:
- Reset (reset=0, asynchronous): queue emptied, pointers 0; branch=taken=mispredict=res_error=0; count_* = 0; empty=1, pred_ready=1. Reset mid-operation discards all entries immediately.
- pred_ready = !full and empty are decoded from registered occupancy only; a pop in the same cycle does not raise pred_ready.
- Push: pred_valid && pred_ready on a rising edge writes pred_taken at tail. pred_valid while !pred_ready is dropped, with no error.
- Resolve: when res_valid && !empty (occupancy at start of cycle), the head is popped and compared with res_taken.
- Outputs are registered, latency 1. The cycle after resolution: branch=1, taken=res_taken, mispredict=(head != res_taken). All three return to 0 unless another resolution occurs.
- Mispredict flush: on a mismatching resolution, every entry is discarded (head, younger entries, and any push in the same cycle). The next cycle shows empty=1, pred_ready=1.
- Correct resolution with simultaneous push: pop and push both occur and occupancy is unchanged.
- res_valid with empty=1: nothing is popped and no branch/taken/mispredict pulse occurs. res_error is set next cycle and stays set until reset. A push in the same cycle still proceeds.
- Counters:
  - count_branches increments by 1 per successful resolution.
  - count_mispred increments by 1 per mismatch.
  - Both hold at all-ones, with no wrap.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.

Decomposition:
- Shared package: DEPTH/STAT_W defaults, pointer-width constant PTR_W = log2(DEPTH), occupancy width PTR_W+1.
- One sub-module, pred_fifo: 1-bit-wide synchronous FIFO with push, pop, flush, full, empty, head data.
- branch_resolve holds the compare, output registers, error flag and counters.

Test Plan:
- Reset, then push T,N,T, then resolve T,N,T on consecutive cycles -> branch=1 for 3 cycles with taken=1,0,1; mispredict=0; count_branches=3, count_mispred=0; empty=1 afterwards.
- Push 4 entries (DEPTH=4) -> pred_ready=0; 5th push ignored; resolve one -> pred_ready=1 the cycle after the pop.
- Push T,T,N, then resolve N -> next cycle mispredict=1, taken=0, empty=1, count_mispred=1; the remaining two entries are gone.
- res_valid=1 with empty queue -> no branch pulse, res_error=1 next cycle and held; counters unchanged.
- STAT_W=4: 16 mispredicting push/resolve pairs -> count_mispred=15, count_branches=15 (saturated).
- Drive reset low mid-stream with 2 entries queued -> outputs and counters 0 and empty=1 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared defaults and width helpers for the branch resolution slice
package branch_resolve_pkg;
   localparam int DEPTH_DEF  = 4;
   localparam int STAT_W_DEF = 16;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/branch_resolve_pred_fifo.sv
// pred_fifo: 1-bit in-order prediction queue with push, pop and whole-queue flush
// ports: clk, reset (async active-low), push/din, pop, flush in; full, empty, head out
module pred_fifo
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   input  logic flush,
   output logic full,
   output logic empty,
   output logic head
);
   localparam int PTR_W = ptr_w(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   logic [DEPTH-1:0] mem;
   logic [PTR_W-1:0] wr, rd;
   logic [OCC_W-1:0] occ;
   logic             wr_en, rd_en;
   assign full  = occ == OCC_W'(DEPTH);
   assign empty = occ == '0;
   assign head  = mem[rd];
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   // flush wins over a same-cycle push: the whole queue is discarded
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr  <= '0;
         rd  <= '0;
         occ <= '0;
      end else if (flush) begin
         wr  <= '0;
         rd  <= '0;
         occ <= '0;
      end else begin
         wr  <= wr + PTR_W'(wr_en);
         rd  <= rd + PTR_W'(rd_en);
         occ <= occ + OCC_W'(wr_en) - OCC_W'(rd_en);
      end
   always_ff @(posedge clk)
      if (wr_en) mem[wr] <= din;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: matches queued predictions against resolved outcomes, drives predictor update and flush
// ports: clk, reset (async active-low); pred_valid/pred_taken/pred_ready issue side;
//        res_valid/res_taken resolve side; branch/taken/mispredict registered pulses;
//        empty, sticky res_error, saturating count_branches/count_mispred
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int STAT_W = STAT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pred_valid,
   input  logic              pred_taken,
   output logic              pred_ready,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              branch,
   output logic              taken,
   output logic              mispredict,
   output logic              empty,
   output logic              res_error,
   output logic [STAT_W-1:0] count_branches,
   output logic [STAT_W-1:0] count_mispred
);
   logic full, head, pop, mis;
   assign pred_ready = !full;
   assign pop        = res_valid && !empty;
   assign mis        = pop && (head != res_taken);
   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (pred_valid),
      .din   (pred_taken),
      .pop   (pop),
      .flush (mis),
      .full  (full),
      .empty (empty),
      .head  (head)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         branch         <= 1'b0;
         taken          <= 1'b0;
         mispredict     <= 1'b0;
         res_error      <= 1'b0;
         count_branches <= '0;
         count_mispred  <= '0;
      end else begin
         branch         <= pop;
         taken          <= pop && res_taken;
         mispredict     <= mis;
         res_error      <= res_error || (res_valid && empty);
         count_branches <= (pop && !(&count_branches)) ? count_branches + 1'b1 : count_branches;
         count_mispred  <= (mis && !(&count_mispred)) ? count_mispred + 1'b1 : count_mispred;
      end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: random and directed stimulus against a queue-based reference model
module tb_branch_resolve;
   localparam int DEPTH  = 4;
   localparam int STAT_W = 4;
   localparam int SAT    = (1 << STAT_W) - 1;
   logic clk = 0, reset = 0;
   logic pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
   logic pred_ready, branch, taken, mispredict, empty, res_error;
   logic [STAT_W-1:0] count_branches, count_mispred;
   int n_cmp = 0, n_bad = 0;
   bit chk = 0;
   bit q[$];
   bit eb = 0, et = 0, em = 0, eerr = 0;
   int cb = 0, cm = 0;

   branch_resolve #(.DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken),
      .branch(branch), .taken(taken), .mispredict(mispredict),
      .empty(empty), .res_error(res_error),
      .count_branches(count_branches), .count_mispred(count_mispred)
   );

   always #5 clk = ~clk;

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
      end
   endtask

   // reference model: a plain queue of predictions, stepped from the inputs each clock
   always @(posedge clk or negedge reset)
      if (!reset) begin
         q.delete();
         eb = 0; et = 0; em = 0; eerr = 0; cb = 0; cm = 0;
      end else begin
         bit was_full, was_empty, p, m;
         was_full  = q.size() == DEPTH;
         was_empty = q.size() == 0;
         p = res_valid && !was_empty;
         m = p && (q[0] != res_taken);
         eb = p;
         et = p && res_taken;
         em = m;
         if (res_valid && was_empty) eerr = 1;
         if (p) cb = (cb < SAT) ? cb + 1 : SAT;
         if (m) cm = (cm < SAT) ? cm + 1 : SAT;
         if (m) q.delete();
         else begin
            if (p) void'(q.pop_front());
            if (pred_valid && !was_full) q.push_back(pred_taken);
         end
      end

   always @(negedge clk)
      if (chk) begin
         check("branch", branch, eb);
         check("taken", taken, et);
         check("mispredict", mispredict, em);
         check("res_error", res_error, eerr);
         check("empty", empty, q.size() == 0);
         check("pred_ready", pred_ready, q.size() < DEPTH);
         check("count_branches", count_branches, cb);
         check("count_mispred", count_mispred, cm);
      end

   task automatic step(input bit pv, input bit pt, input bit rv, input bit rt);
      pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #7;
      check("rst_empty", empty, 1);
      check("rst_ready", pred_ready, 1);
      check("rst_cnt", count_branches, 0);
      reset = 1;
      chk = 1;
      @(negedge clk);
      // in-order correct resolutions
      step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
      step(0, 0, 1, 1); check("t1_b0", {branch, taken, mispredict}, 3'b110);
      step(0, 0, 1, 0); check("t1_b1", {branch, taken, mispredict}, 3'b100);
      step(0, 0, 1, 1); check("t1_b2", {branch, taken, mispredict}, 3'b110);
      check("t1_cb", count_branches, 3);
      check("t1_cm", count_mispred, 0);
      step(0, 0, 0, 0); check("t1_empty", empty, 1);
      // fill, overflow push dropped, ready returns after a pop
      repeat (4) step(1, 1, 0, 0);
      check("t2_full", pred_ready, 0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 1); check("t2_ready", pred_ready, 1);
      repeat (3) step(0, 0, 1, 1);
      check("t2_empty", empty, 1);
      check("t2_cm", count_mispred, 0);
      // mispredict flushes the younger entries
      step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      check("t3_mis", {branch, taken, mispredict}, 3'b101);
      check("t3_empty", empty, 1);
      check("t3_cm", count_mispred, 1);
      // resolution with an empty queue
      step(0, 0, 1, 1);
      check("t4_err", res_error, 1);
      check("t4_b", branch, 0);
      check("t4_cb", count_branches, 8);
      step(0, 0, 0, 0); check("t4_hold", res_error, 1);
      // counters saturate
      repeat (16) begin step(1, 1, 0, 0); step(0, 0, 1, 0); end
      check("t5_cm", count_mispred, 15);
      check("t5_cb", count_branches, 15);
      // asynchronous reset mid-stream
      step(1, 1, 0, 0); step(1, 0, 0, 0);
      pred_valid = 0;
      #2 reset = 0;
      #1;
      check("t6_empty", empty, 1);
      check("t6_ready", pred_ready, 1);
      check("t6_cnt", {count_branches, count_mispred}, 0);
      check("t6_out", {branch, taken, mispredict, res_error}, 0);
      #1 reset = 1;
      @(negedge clk);
      // randomized traffic, resolutions mostly matching the queued prediction
      repeat (3000) begin
         bit rv, rt;
         rv = ($urandom % 3) == 0;
         rt = q.size() != 0 ? (($urandom % 6 == 0) ? !q[0] : q[0]) : 1'($urandom);
         if (q.size() == 0 && ($urandom % 8) != 0) rv = 0;
         step(($urandom % 4) != 0, 1'($urandom), rv, rt);
      end
      chk = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
